// File: rtl/spdp_serial_membus.sv
// spdp_serial_membus
//   Bit-serial memory-bus master for the serial PDP core family. Takes one
//   parallel word request from the CPU side and runs it as a framed serial
//   transfer on the pin bus:
//     ADDR (1 cycle) -> TURN (reads only, TURN_CYC cycles) -> XFER (BEATS
//     beats, LSB-first) -> [PAR beat] -> DONE (1 cycle).
//
//   Optional feature macro: SPDP_MEMBUS_PARITY_EN
//     Defined   : one extra PAR beat after the last XFER beat. Lane 0 carries
//                 the even parity (XOR) of the word. Writes drive it, and
//                 reads check it and report a mismatch on perr_o.
//     Undefined : no PAR beat, perr_o tied low.
//
// Ports
//   clk_i         system clock
//   rst_n_i       synchronous active-low reset
//   req_i         transaction request, only sampled while ready_o=1
//   we_i          1=write, 0=read, captured with req_i
//   addr_i        word address, captured with req_i
//   wdata_i       write data, captured with req_i
//   ready_o       idle, a request is accepted this cycle
//   done_o        one-cycle completion pulse
//   rdata_o       read data, valid from done_o, held until the next read
//   perr_o        parity error, valid with done_o
//   mem_addr_o    pin address, stable for the whole frame, held when idle
//   mem_active_o  frame strobe, high from ADDR through the last beat
//   mem_write_o   high during write data (and parity) beats
//   mb_out_o      serial write data lanes
//   mb_in_i       serial read data lanes
module spdp_serial_membus #(
  parameter int WORD_W   = 12,
  parameter int ADDR_W   = 11,
  parameter int LANES    = 1,
  parameter int TURN_CYC = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              perr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_active_o,
  output logic              mem_write_o,
  output logic [LANES-1:0]  mb_out_o,
  input  logic [LANES-1:0]  mb_in_i
);

  localparam int BEATS  = WORD_W / LANES;
  localparam int BCNT_W = $clog2(BEATS + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  // Only compared while in TURN, which is never entered when TURN_CYC=0.
  localparam logic [2:0]        LAST_TURN = 3'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_TURN,
    S_XFER,
    S_PAR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [2:0]          turn_q, turn_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
`ifdef SPDP_MEMBUS_PARITY_EN
  logic                par_q, par_d;
  logic                perr_q, perr_d;
`endif

  // Control registers: reset applies here.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      mem_addr_q <= '0;
      beat_q     <= '0;
      turn_q     <= '0;
      rdata_q    <= '0;
`ifdef SPDP_MEMBUS_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      mem_addr_q <= mem_addr_d;
      beat_q     <= beat_d;
      turn_q     <= turn_d;
      rdata_q    <= rdata_d;
`ifdef SPDP_MEMBUS_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // Datapath registers: fully reloaded on every accept, no reset needed.
  always_ff @(posedge clk_i) begin
    sh_q <= sh_d;
`ifdef SPDP_MEMBUS_PARITY_EN
    par_q <= par_d;
`endif
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    mem_addr_d = mem_addr_q;
    sh_d       = sh_q;
    beat_d     = beat_q;
    turn_d     = turn_q;
    rdata_d    = rdata_q;
`ifdef SPDP_MEMBUS_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d    = S_ADDR;
          we_d       = we_i;
          mem_addr_d = addr_i;
          sh_d       = wdata_i;
`ifdef SPDP_MEMBUS_PARITY_EN
          par_d      = ^wdata_i;
`endif
        end
      end

      S_ADDR: begin
        beat_d = '0;
        turn_d = '0;
        if (!we_q && (TURN_CYC > 0)) state_d = S_TURN;
        else                         state_d = S_XFER;
      end

      S_TURN: begin
        turn_d = turn_q + 3'd1;
        if (turn_q == LAST_TURN) state_d = S_XFER;
      end

      S_XFER: begin
        beat_d = beat_q + 1'b1;
        // Writes shift the word out from the LSB end; reads shift lanes in
        // from the MSB end so beat 0 lands in the low bits after BEATS beats.
        sh_d   = sh_q >> LANES;
        if (!we_q) sh_d = sh_d | (WORD_W'(mb_in_i) << (WORD_W - LANES));
        if (beat_q == LAST_BEAT) begin
`ifdef SPDP_MEMBUS_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_DONE;
          if (!we_q) rdata_d = sh_d;
`endif
        end
      end

      S_PAR: begin
        state_d = S_DONE;
`ifdef SPDP_MEMBUS_PARITY_EN
        if (!we_q) begin
          rdata_d = sh_q;
          perr_d  = (^sh_q) ^ mb_in_i[0];
        end
`endif
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin and handshake outputs, decoded from state
  always_comb begin
    ready_o      = (state_q == S_IDLE);
    done_o       = (state_q == S_DONE);
    mem_active_o = (state_q == S_ADDR) || (state_q == S_TURN) ||
                   (state_q == S_XFER) || (state_q == S_PAR);
    mem_write_o  = we_q && ((state_q == S_XFER) || (state_q == S_PAR));
    mb_out_o     = '0;
    if (we_q && (state_q == S_XFER)) mb_out_o = sh_q[LANES-1:0];
`ifdef SPDP_MEMBUS_PARITY_EN
    if (we_q && (state_q == S_PAR))  mb_out_o = LANES'(par_q);
`endif
  end

  assign mem_addr_o = mem_addr_q;
  assign rdata_o    = rdata_q;
`ifdef SPDP_MEMBUS_PARITY_EN
  assign perr_o     = perr_q;
`else
  assign perr_o     = 1'b0;
`endif

endmodule

// File: tb/tb_spdp_serial_membus.sv
// Bench for spdp_serial_membus. Two instances share the clock and reset:
//   A: WORD_W=12, LANES=1, TURN_CYC=1
//   B: WORD_W=12, LANES=4, TURN_CYC=0
// The expected frame is derived per cycle from the frame layout
// (ADDR, TURN, LSB-first beats, optional parity beat, DONE).
module tb_spdp_serial_membus;

`ifdef SPDP_MEMBUS_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req, we;
  logic [10:0] addr;
  logic [11:0] wdata;
  logic [3:0]  mbi;
  int          sel;

  logic        req_a, req_b;
  logic        rdy_a, done_a, perr_a, act_a, wr_a;
  logic        rdy_b, done_b, perr_b, act_b, wr_b;
  logic [11:0] rd_a, rd_b;
  logic [10:0] ma_a, ma_b;
  logic [0:0]  mbo_a;
  logic [3:0]  mbo_b;

  logic        o_ready, o_done, o_perr, o_act, o_wr;
  logic [11:0] o_rdata;
  logic [10:0] o_maddr;
  logic [3:0]  o_mbo;

  logic [10:0] last_addr  [2];
  logic [11:0] last_rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  assign req_a = req && (sel == 0);
  assign req_b = req && (sel == 1);

  spdp_serial_membus #(.WORD_W(12), .ADDR_W(11), .LANES(1), .TURN_CYC(1)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(rdy_a), .done_o(done_a), .rdata_o(rd_a),
    .perr_o(perr_a), .mem_addr_o(ma_a), .mem_active_o(act_a),
    .mem_write_o(wr_a), .mb_out_o(mbo_a), .mb_in_i(mbi[0:0])
  );

  spdp_serial_membus #(.WORD_W(12), .ADDR_W(11), .LANES(4), .TURN_CYC(0)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ready_o(rdy_b), .done_o(done_b), .rdata_o(rd_b),
    .perr_o(perr_b), .mem_addr_o(ma_b), .mem_active_o(act_b),
    .mem_write_o(wr_b), .mb_out_o(mbo_b), .mb_in_i(mbi)
  );

  always_comb begin
    o_ready = (sel == 1) ? rdy_b  : rdy_a;
    o_done  = (sel == 1) ? done_b : done_a;
    o_perr  = (sel == 1) ? perr_b : perr_a;
    o_act   = (sel == 1) ? act_b  : act_a;
    o_wr    = (sel == 1) ? wr_b   : wr_a;
    o_rdata = (sel == 1) ? rd_b   : rd_a;
    o_maddr = (sel == 1) ? ma_b   : ma_a;
    o_mbo   = (sel == 1) ? mbo_b  : {3'b000, mbo_a};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, got, exp);
    end
  endtask

  function automatic string tg(input string n, input int c);
    return $sformatf("%s@%0d", n, c);
  endfunction

  // Idle cycles on the selected instance: bus quiet, address and read data held.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", o_ready, 1);
      check("idle_done",  o_done,  0);
      check("idle_act",   o_act,   0);
      check("idle_wr",    o_wr,    0);
      check("idle_mbo",   o_mbo,   0);
      check("idle_perr",  o_perr,  0);
      check("idle_maddr", o_maddr, last_addr[sel]);
      check("idle_rdata", o_rdata, last_rdata[sel]);
      req   = 1'b0;
      addr  = 11'($urandom);
      wdata = 12'($urandom);
      mbi   = 4'($urandom);
    end
  endtask

  // One transaction on instance s. For reads, d is the word the memory
  // returns; badpar flips the returned parity bit. req stays high with
  // random payload for the whole frame (must be ignored). rst_at>0 pulls
  // reset during that frame cycle.
  task automatic run_txn(input int s, input bit w, input logic [10:0] a,
                         input logic [11:0] d, input bit badpar, input int rst_at);
    int L, beats, fb, dc, k, mask;
    bit in_beat, in_par, pbit, hit_rst;
    logic [3:0] exp_mbo;
    L     = (s == 1) ? 4 : 1;
    beats = 12 / L;
    fb    = 2 + ((w || s == 1) ? 0 : 1);
    dc    = fb + beats + P;
    mask  = (1 << L) - 1;
    pbit  = (^d) ^ badpar;
    hit_rst = 1'b0;
    if (sel != s) begin
      req = 1'b0;
      sel = s;
    end
    @(negedge clk);
    check("accept_ready", o_ready, 1);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = w ? d : 12'($urandom);
    mbi   = 4'($urandom);
    for (int c = 1; c <= dc; c++) begin
      @(negedge clk);
      k       = c - fb;
      in_beat = (c >= fb) && (c < fb + beats);
      in_par  = (P == 1) && (c == fb + beats);
      exp_mbo = '0;
      if (w && in_beat) exp_mbo = 4'((d >> (k * L)) & mask);
      if (w && in_par)  exp_mbo = {3'b000, ^d};
      check(tg("ready", c), o_ready, 0);
      check(tg("done",  c), o_done,  (c == dc) ? 1 : 0);
      check(tg("act",   c), o_act,   (c < dc) ? 1 : 0);
      check(tg("wr",    c), o_wr,    (w && c >= fb && c < dc) ? 1 : 0);
      check(tg("mbo",   c), o_mbo,   exp_mbo);
      check(tg("maddr", c), o_maddr, a);
      check(tg("rdata", c), o_rdata, (c == dc && !w) ? d : last_rdata[s]);
      check(tg("perr",  c), o_perr,  (c == dc && !w && P == 1) ? badpar : 0);
      req   = 1'b1;
      we    = 1'($urandom);
      addr  = 11'($urandom);
      wdata = 12'($urandom);
      mbi   = 4'($urandom);
      if (!w && in_beat) mbi = 4'((d >> (k * L)) & mask);
      if (!w && in_par)  mbi = {3'($urandom), pbit};
      if (c == rst_at) begin
        rst_n   = 1'b0;
        req     = 1'b0;
        hit_rst = 1'b1;
        break;
      end
    end
    if (hit_rst) begin
      @(negedge clk);
      check("rst_ready", o_ready, 1);
      check("rst_act",   o_act,   0);
      check("rst_wr",    o_wr,    0);
      check("rst_mbo",   o_mbo,   0);
      check("rst_done",  o_done,  0);
      check("rst_rdata", o_rdata, 0);
      check("rst_maddr", o_maddr, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        last_addr[i]  = '0;
        last_rdata[i] = '0;
      end
    end else begin
      last_addr[s] = a;
      if (!w) last_rdata[s] = d;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    mbi   = '0;
    sel   = 0;
    for (int i = 0; i < 2; i++) begin
      last_addr[i]  = '0;
      last_rdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("reset_ready", o_ready, 1);
      check("reset_done",  o_done,  0);
      check("reset_perr",  o_perr,  0);
      check("reset_rdata", o_rdata, 0);
      check("reset_maddr", o_maddr, 0);
      check("reset_act",   o_act,   0);
      check("reset_wr",    o_wr,    0);
      check("reset_mbo",   o_mbo,   0);
    end
    rst_n = 1'b1;
    sel   = 0;
    idle(2);

    // Directed frames on the 1-lane instance
    run_txn(0, 1'b1, 11'h2A5, 12'hF01, 1'b0, 0);
    idle(2);
    run_txn(0, 1'b0, 11'h155, 12'h29C, 1'b0, 0);
    idle(1);
    run_txn(0, 1'b0, 11'h0AA, 12'h29C, 1'b1, 0);
    // Back-to-back with req held high throughout
    run_txn(0, 1'b1, 11'h7FF, 12'h000, 1'b0, 0);
    run_txn(0, 1'b0, 11'h001, 12'hFFF, 1'b0, 0);
    run_txn(0, 1'b1, 11'h400, 12'hA5A, 1'b0, 0);
    idle(1);
    // Reset during write beat 5, then a normal read
    run_txn(0, 1'b1, 11'h123, 12'h5C3, 1'b0, 2 + 5);
    idle(1);
    run_txn(0, 1'b0, 11'h321, 12'h3A7, 1'b0, 0);

    // Directed frames on the 4-lane instance
    run_txn(1, 1'b1, 11'h2A5, 12'hF01, 1'b0, 0);
    idle(1);
    run_txn(1, 1'b0, 11'h066, 12'h29C, 1'b1, 0);
    run_txn(1, 1'b0, 11'h067, 12'hC35, 1'b0, 0);

    // Random traffic across both instances
    for (int i = 0; i < 40; i++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 11'($urandom),
              12'($urandom), 1'($urandom), 0);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
